// File: rtl/rd_fram_pkg.sv
// Shared sizing constants for the frame-buffer read unpacker and its wide-word FIFO.
package rd_fram_pkg;

  localparam int unsigned IN_WIDTH_DEF    = 256;
  localparam int unsigned OUT_WIDTH_DEF   = 32;
  localparam int unsigned FRAME_WORDS_DEF = 1024;
  localparam int unsigned RATIO           = IN_WIDTH_DEF / OUT_WIDTH_DEF;
  localparam int unsigned LANE_W          = $clog2(RATIO);
  localparam int unsigned LEVEL_W         = 2;
  localparam int unsigned FIFO_DEPTH      = 2;

endpackage

// File: rtl/fram_wide_fifo.sv
// Two-entry FIFO of wide frame-buffer words; exposes occupancy and the head word.
module fram_wide_fifo
  import rd_fram_pkg::*;
#(
  parameter int unsigned WIDTH = IN_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [LEVEL_W-1:0] level,
  output logic [WIDTH-1:0]   head
);

  logic [WIDTH-1:0]   mem [FIFO_DEPTH];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [LEVEL_W-1:0] count;
  logic               do_push;
  logic               do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push && (count < LEVEL_W'(FIFO_DEPTH)) && !flush;
  assign do_pop  = pop && (count != '0) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + LEVEL_W'(1);
        2'b01:   count <= count - LEVEL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign level = count;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/rd_fram_unpack.sv
// Unpacks wide frame-buffer read words into narrow pixel words, LSB lane first,
// tracking position within the frame for last-word marking and a done pulse.
module rd_fram_unpack
  import rd_fram_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = IN_WIDTH_DEF,
  parameter int unsigned OUT_WIDTH   = OUT_WIDTH_DEF,
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 frame_done,
  output logic [1:0]           level
);

  localparam int unsigned N_LANES   = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned LANE_BITS = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int unsigned WCNT_W    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  logic [LEVEL_W-1:0]                fifo_level;
  logic [IN_WIDTH-1:0]               head;
  logic [N_LANES-1:0][OUT_WIDTH-1:0] head_lanes;
  logic [LANE_BITS-1:0]              lane;
  logic [WCNT_W-1:0]                 wcnt;
  logic                              rdy_en;
  logic                              push;
  logic                              pop;
  logic                              hs;
  logic                              last_lane;
  logic                              last_word;

  fram_wide_fifo #(
    .WIDTH(IN_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .level     (fifo_level),
    .head      (head)
  );

  assign head_lanes = head;

  // Holds in_ready low through reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  assign level     = fifo_level;
  assign out_valid = (fifo_level != '0);
  assign in_ready  = rdy_en && (fifo_level < LEVEL_W'(FIFO_DEPTH)) && !flush;
  assign hs        = out_valid && out_ready && !flush;
  assign last_lane = (lane == LANE_BITS'(N_LANES - 1));
  assign last_word = (wcnt == WCNT_W'(FRAME_WORDS - 1));
  assign push      = in_valid && in_ready;
  assign pop       = hs && last_lane;

  assign out_data  = out_valid ? head_lanes[lane] : '0;
  assign out_last  = out_valid && last_word;

  // Lane and frame-position counters advance only on a narrow handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane       <= '0;
      wcnt       <= '0;
      frame_done <= 1'b0;
    end else if (flush) begin
      lane       <= '0;
      wcnt       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= hs && last_word;
      if (hs) begin
        lane <= last_lane ? '0 : lane + LANE_BITS'(1);
        wcnt <= last_word ? '0 : wcnt + WCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rd_fram_unpack.sv
// Randomized and directed bench for rd_fram_unpack against a narrow-word queue model.
module tb_rd_fram_unpack;

  localparam int unsigned IW = 256;
  localparam int unsigned OW = 32;
  localparam int unsigned R  = IW / OW;
  localparam int unsigned FW = 1024;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          frame_done;
  logic [1:0]    level;

  rd_fram_unpack #(
    .IN_WIDTH    (IW),
    .OUT_WIDTH   (OW),
    .FRAME_WORDS (FW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_done (frame_done),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: every narrow word still owed to the consumer, in order.
  logic [OW-1:0] q[$];
  int unsigned   wcount;
  bit            rdy_m;
  bit            fd_m;

  // Per-step observations used by the directed tests.
  bit          acc_g;
  bit          hs_g;
  bit          dut_last_hs;
  int unsigned hs_total;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int unsigned exp_level();
    return (int'(q.size()) + R - 1) / R;
  endfunction

  function automatic logic [IW-1:0] rand_word();
    logic [IW-1:0] d;
    for (int i = 0; i < int'(R); i++) d[i*OW +: OW] = $urandom;
    return d;
  endfunction

  function automatic logic [IW-1:0] lane_word(input int unsigned base);
    logic [IW-1:0] d;
    for (int i = 0; i < int'(R); i++) d[i*OW +: OW] = OW'(base + i);
    return d;
  endfunction

  task automatic check_all();
    bit v;
    v = (q.size() != 0);
    chk("out_valid", 32'(out_valid), 32'(v));
    chk("level", 32'(level), exp_level());
    chk("out_data", 32'(out_data), v ? 32'(q[0]) : 32'd0);
    chk("out_last", 32'(out_last), 32'(v && (wcount == FW - 1)));
    chk("frame_done", 32'(frame_done), 32'(fd_m));
  endtask

  // One clock: drive after the falling edge, advance the model, check at the next falling edge.
  task automatic step(input bit iv, input logic [IW-1:0] d, input bit ordy, input bit fl);
    bit eir;
    bit hs;
    bit acc;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    eir = rdy_m && (exp_level() < 2) && !fl;
    chk("in_ready", 32'(in_ready), 32'(eir));
    hs  = (q.size() != 0) && ordy && !fl;
    acc = iv && eir;
    dut_last_hs = out_valid && out_ready && !flush && out_last;
    acc_g = acc;
    hs_g  = hs;
    fd_m  = hs && (wcount == FW - 1);
    if (fl) begin
      q.delete();
      wcount = 0;
    end else begin
      if (hs) begin
        void'(q.pop_front());
        wcount = (wcount + 1) % FW;
        hs_total++;
      end
      if (acc) for (int i = 0; i < int'(R); i++) q.push_back(d[i*OW +: OW]);
    end
    rdy_m = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // Asynchronous reset pulse issued between clock edges; entered and left at a falling edge.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    q.delete();
    wcount = 0;
    fd_m   = 1'b0;
    rdy_m  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_data   = '0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_frame_done", 32'(frame_done), 32'd0);
    end
    #2 rst_n = 1'b1;
    #1 chk("rel_in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rdy_m = 1'b1;
    check_all();
    chk("rel_in_ready_after_edge", 32'(in_ready), 32'd1);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    chk(nm, 32'(q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc_cnt;
    int last_cnt;
    int fd_cnt;
    int last_idx;
    int unsigned hs_start;
    logic [IW-1:0] w;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    hs_total = 0; wcount = 0; rdy_m = 1'b0; fd_m = 1'b0;
    @(negedge clk);
    pulse_reset();

    // Lane ordering and first-word latency.
    step(1'b1, lane_word(0), 1'b1, 1'b0);
    chk("t1_first_lane", 32'(out_data), 32'd0);
    chk("t1_first_valid", 32'(out_valid), 32'd1);
    for (int i = 1; i < int'(R); i++) begin
      step(1'b0, '0, 1'b1, 1'b0);
      chk($sformatf("t1_lane%0d", i), 32'(out_data), 32'(i));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    chk("t1_level_empty", 32'(level), 32'd0);
    chk("t1_valid_empty", 32'(out_valid), 32'd0);

    // Backpressure fills both entries and the head lane holds.
    step(1'b1, lane_word(100), 1'b0, 1'b0);
    step(1'b1, lane_word(200), 1'b0, 1'b0);
    step(1'b1, lane_word(300), 1'b0, 1'b0);
    chk("t2_level_full", 32'(level), 32'd2);
    chk("t2_in_ready_low", 32'(in_ready), 32'd0);
    chk("t2_head_hold", 32'(out_data), 32'd100);
    drain("t2_drain");

    // Flush at lane 3 of word 5 with push and pop requested together.
    step(1'b0, '0, 1'b0, 1'b1);
    n = 0;
    while (wcount != 5 * R + 3 && n < 200) begin
      step(exp_level() == 0, rand_word(), 1'b1, 1'b0);
      n++;
    end
    chk("t3_reach_lane3_word5", wcount, 5 * R + 3);
    step(1'b1, rand_word(), 1'b1, 1'b1);
    chk("t3_flush_level", 32'(level), 32'd0);
    chk("t3_flush_valid", 32'(out_valid), 32'd0);
    step(1'b1, lane_word(500), 1'b1, 1'b0);
    chk("t3_post_flush_lane0", 32'(out_data), 32'd500);
    drain("t3_drain");

    // One full frame with continuous traffic.
    step(1'b0, '0, 1'b0, 1'b1);
    acc_cnt = 0; last_cnt = 0; fd_cnt = 0; last_idx = -1; n = 0;
    hs_start = hs_total;
    while ((acc_cnt < int'(FW / R) || q.size() != 0) && n < 3000) begin
      step(acc_cnt < int'(FW / R), rand_word(), 1'b1, 1'b0);
      if (acc_g) acc_cnt++;
      if (dut_last_hs) begin
        last_cnt++;
        last_idx = int'(hs_total - hs_start) - 1;
      end
      if (frame_done) fd_cnt++;
      n++;
    end
    step(1'b0, '0, 1'b1, 1'b0);
    if (frame_done) fd_cnt++;
    chk("t4_accepts", 32'(acc_cnt), FW / R);
    chk("t4_last_count", 32'(last_cnt), 32'd1);
    chk("t4_last_index", 32'(last_idx), FW - 1);
    chk("t4_frame_done_count", 32'(fd_cnt), 32'd1);

    // Four frames under random backpressure on both sides.
    acc_cnt = 0; fd_cnt = 0; n = 0;
    hs_start = hs_total;
    while ((acc_cnt < int'(4 * FW / R) || q.size() != 0) && n < 40000) begin
      step((acc_cnt < int'(4 * FW / R)) && $urandom_range(1), rand_word(),
           1'($urandom_range(1)), 1'b0);
      if (acc_g) acc_cnt++;
      if (frame_done) fd_cnt++;
      n++;
    end
    step(1'b0, '0, 1'b0, 1'b0);
    if (frame_done) fd_cnt++;
    chk("t5_words_out", hs_total - hs_start, 4 * FW);
    chk("t5_frame_done_count", 32'(fd_cnt), 32'd4);

    // Reset mid-frame with both entries occupied.
    step(1'b1, rand_word(), 1'b1, 1'b0);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);
    w = rand_word();
    step(1'b1, w, 1'b0, 1'b0);
    chk("t6_level_full", 32'(level), 32'd2);
    pulse_reset();
    step(1'b1, lane_word(7), 1'b1, 1'b0);
    chk("t6_restart_lane0", 32'(out_data), 32'd7);
    chk("t6_restart_not_last", 32'(out_last), 32'd0);
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
